boxcar_decimator: RTL and testbench
===================================

// Module: boxcar_decimator
//
// PURPOSE
//  Boxcar (moving-block) averaging decimator directly upstream of the FFT repeating buffer.
//  Accepts a stream of signed samples with a valid strobe.
//  Sums non-overlapping blocks of 2^L samples and emits one scaled, rounded average per block.
//  The output is a sparse single-cycle o_valid strobe with OUT_WIDTH-bit data, the format the repeating buffer consumes.
//
// PARAMETERS
//  IN_WIDTH   16  signed input sample width
//  OUT_WIDTH  17  signed output width; must be >= IN_WIDTH; K = OUT_WIDTH-IN_WIDTH extra LSBs of precision
//  MAX_LOG2   5   largest supported log2 decimation ratio (block of up to 32 samples)
//
// PORTS
//  i_clk          in   1                     system clock; all logic on rising edge
//  i_reset        in   1                     synchronous, active-high reset
//  i_enable       in   1                     1 = decimate; 0 = flush partial block, emit nothing
//  i_log2_decim   in   $clog2(MAX_LOG2+1)    requested L; values > MAX_LOG2 are clamped to MAX_LOG2
//  i_valid        in   1                     i_data qualifier; may be high every cycle
//  i_data         in   IN_WIDTH              signed input sample
//  o_valid        out  1                     single-cycle strobe, one per completed block
//  o_data         out  OUT_WIDTH             signed block result; held between strobes
//  o_active_log2  out  $clog2(MAX_LOG2+1)    L in use for the current/last block
//
// BEHAVIOUR
//  Reset:
//   - i_reset=1 at a clock edge clears acc, count, o_valid, o_data and o_active_log2 to 0.
//   - State returns to IDLE.
//  States:
//   - IDLE: count=0, no partial block.
//   - ACCUM: 1 <= count < 2^L.
//  Accepted sample: i_valid & i_enable & !i_reset.
//  Latching L:
//   - In IDLE, an accepted sample latches L = min(i_log2_decim, MAX_LOG2) into o_active_log2.
//   - The latched L is fixed for the whole block; i_log2_decim changes mid-block take effect at the next block.
//  Accumulator:
//   - Signed, IN_WIDTH+MAX_LOG2 bits; cannot overflow.
//   - On an accepted sample: acc <= acc + i_data; count <= count + 1.
//  Block complete:
//   - An accepted sample that makes count reach 2^L completes the block.
//   - Let S = (acc + i_data) <<< K.
//   - Rounded result: R = (S + (L>0 ? 2^(L-1) : 0)) >>> L (round half up, arithmetic shift).
//   - o_data <= R[OUT_WIDTH-1:0]; R always fits, so no saturation.
//   - o_valid <= 1 for exactly one cycle.
//   - acc and count clear; state returns to IDLE.
//   - The same-cycle next sample starts the new block with no lost samples.
//  L = 0: every accepted sample produces an output, o_data = i_data <<< K, one per accepted cycle.
//  Latency: o_valid is asserted on the edge after the completing sample's edge (1 cycle).
//  i_valid=0 cycles are ignored; the block spans however many cycles 2^L valids take.
//  i_enable=0:
//   - Clears acc and count and returns to IDLE; the partial block is discarded.
//   - o_valid is 0 next cycle; o_data holds its last value.
//  Reset mid-block: the partial block is discarded; the first output follows 2^L accepted samples after release.
//  No backpressure: the downstream stage always accepts o_valid.
//
// TESTING
//  1. L=0, i_valid every cycle with i_data=100,-7 -> o_data=200,-14, one cycle later each, o_valid continuous.
//  2. L=2, samples 1,0,0,0 -> o_data=1; then -1,0,0,0 -> o_data=0 (round half up); o_valid high 1 cycle only.
//  3. L=5, 32x 32767 -> o_data=65534; 32x -32768 -> o_data=-65536; i_valid 1-in-32 cycles, o_valid once per 1024 cycles.
//  4. L=2, change i_log2_decim to 3 after 2 samples -> the first block still closes after 4 samples (o_active_log2=2); the next block needs 8 samples (o_active_log2=3).
//  5. L=3, drop i_enable after 5 samples, re-enable, feed 8x 10 -> a single output of 20 with no contribution from the discarded 5.
//  6. Assert i_reset mid-block -> all outputs 0 next edge; after release, 2^L samples of 4 -> o_data=8 (K=1).

Source files
------------

// File: rtl/boxcar_decimator.sv
// Boxcar averaging decimator: sums non-overlapping blocks of 2^L signed samples
// and emits one rounded, K-bit-extended average per block as a single-cycle strobe.
//
// state | meaning
// IDLE  | count = 0, no partial block held; next accepted sample latches L
// ACCUM | 1 <= count < 2^L, block in progress with latched L
module boxcar_decimator #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 17,
    parameter int MAX_LOG2  = 5
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_enable,
    input  logic [$clog2(MAX_LOG2+1)-1:0]   i_log2_decim,
    input  logic                            i_valid,
    input  logic [IN_WIDTH-1:0]             i_data,
    output logic                            o_valid,
    output logic [OUT_WIDTH-1:0]            o_data,
    output logic [$clog2(MAX_LOG2+1)-1:0]   o_active_log2
);
    localparam int LW    = $clog2(MAX_LOG2 + 1);
    localparam int K     = OUT_WIDTH - IN_WIDTH;
    localparam int ACC_W = IN_WIDTH + MAX_LOG2;
    localparam int CW    = MAX_LOG2 + 1;
    localparam int SW    = ACC_W + K + 1;
    localparam logic [LW-1:0] L_MAX = LW'(MAX_LOG2);

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    state_t                  state, state_n;
    logic signed [ACC_W-1:0] acc, acc_n;
    logic [CW-1:0]           count, count_n;
    logic                    valid_n;
    logic [OUT_WIDTH-1:0]    data_n;
    logic [LW-1:0]           active_n;

    logic                    accept;
    logic [LW-1:0]           l_req;
    logic [LW-1:0]           l_cur;
    logic [CW-1:0]           count_inc;
    logic [CW-1:0]           block_len;
    logic                    done;
    logic signed [ACC_W-1:0] sum;
    logic signed [SW-1:0]    scaled;
    logic signed [SW-1:0]    rnd;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            acc           <= '0;
            count         <= '0;
            o_valid       <= 1'b0;
            o_data        <= '0;
            o_active_log2 <= '0;
        end else begin
            state         <= state_n;
            acc           <= acc_n;
            count         <= count_n;
            o_valid       <= valid_n;
            o_data        <= data_n;
            o_active_log2 <= active_n;
        end
    end

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        count_n   = count;
        valid_n   = 1'b0;
        data_n    = o_data;
        active_n  = o_active_log2;

        accept    = i_valid & i_enable;
        l_req     = (i_log2_decim > L_MAX) ? L_MAX : i_log2_decim;
        // A block opened this cycle uses the freshly requested L, otherwise the latched one
        l_cur     = (state == IDLE) ? l_req : o_active_log2;
        count_inc = count + CW'(1);
        block_len = CW'(1) << l_cur;
        done      = accept && (count_inc == block_len);

        sum       = acc + {{MAX_LOG2{i_data[IN_WIDTH-1]}}, i_data};
        scaled    = SW'(sum);
        scaled    = scaled <<< K;
        rnd       = SW'((SW'(1) << l_cur) >> 1);

        if (!i_enable) begin
            state_n = IDLE;
            acc_n   = '0;
            count_n = '0;
        end else if (accept) begin
            if (state == IDLE) begin
                active_n = l_req;
            end
            if (done) begin
                data_n  = OUT_WIDTH'((scaled + rnd) >>> l_cur);
                valid_n = 1'b1;
                acc_n   = '0;
                count_n = '0;
                state_n = IDLE;
            end else begin
                acc_n   = sum;
                count_n = count_inc;
                state_n = ACCUM;
            end
        end
    end
endmodule

// File: tb/tb_boxcar_decimator.sv
// Directed self-checking bench for boxcar_decimator (IN_WIDTH=16, OUT_WIDTH=17, MAX_LOG2=5).
module tb_boxcar_decimator;
    logic        clk;
    logic        reset;
    logic        enable;
    logic [2:0]  log2_decim;
    logic        valid_in;
    logic [15:0] data_in;
    logic        valid_out;
    logic [16:0] data_out;
    logic [2:0]  active_log2;

    int checks = 0;
    int errors = 0;
    int pulses;
    int last_data;

    boxcar_decimator #(
        .IN_WIDTH (16),
        .OUT_WIDTH(17),
        .MAX_LOG2 (5)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_log2_decim (log2_decim),
        .i_valid      (valid_in),
        .i_data       (data_in),
        .o_valid      (valid_out),
        .o_data       (data_out),
        .o_active_log2(active_log2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present one cycle of input, then sample just after the capturing edge
    task automatic step(input logic v, input int d);
        valid_in = v;
        data_in  = 16'(d);
        @(posedge clk);
        #1;
    endtask

    function automatic int sdata();
        return int'($signed(data_out));
    endfunction

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        log2_decim = 3'd0;
        valid_in   = 1'b0;
        data_in    = '0;
        @(posedge clk);
        #1;
        check("reset_valid", int'(valid_out), 0);
        check("reset_data", sdata(), 0);
        check("reset_active", int'(active_log2), 0);
        reset  = 1'b0;
        enable = 1'b1;

        // 1. L=0: every sample is its own block
        log2_decim = 3'd0;
        step(1'b1, 100);
        check("l0_valid_a", int'(valid_out), 1);
        check("l0_data_a", sdata(), 200);
        step(1'b1, -7);
        check("l0_valid_b", int'(valid_out), 1);
        check("l0_data_b", sdata(), -14);
        check("l0_active", int'(active_log2), 0);

        // 2. L=2: round half up
        log2_decim = 3'd2;
        step(1'b1, 1);
        check("l2_no_valid_1", int'(valid_out), 0);
        check("l2_hold_data", sdata(), -14);
        step(1'b1, 0);
        step(1'b1, 0);
        check("l2_no_valid_3", int'(valid_out), 0);
        step(1'b1, 0);
        check("l2_valid_a", int'(valid_out), 1);
        check("l2_data_a", sdata(), 1);
        check("l2_active", int'(active_log2), 2);
        step(1'b1, -1);
        check("l2_single_cycle", int'(valid_out), 0);
        step(1'b0, 0);
        step(1'b1, 0);
        step(1'b1, 0);
        step(1'b1, 0);
        check("l2_valid_b", int'(valid_out), 1);
        check("l2_data_b", sdata(), 0);
        step(1'b0, 0);
        check("l2_drop", int'(valid_out), 0);

        // 3. L=5 full-scale positive, then clamped request (7 -> 5) full-scale negative
        log2_decim = 3'd5;
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 32767);
            pulses += int'(valid_out);
            if (valid_out) last_data = sdata();
            for (int j = 0; j < 31; j++) begin
                step(1'b0, 0);
                pulses += int'(valid_out);
            end
        end
        check("l5_pos_pulses", pulses, 1);
        check("l5_pos_data", last_data, 65534);
        log2_decim = 3'd7;
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, -32768);
            pulses += int'(valid_out);
            if (valid_out) last_data = sdata();
            if (i == 0) check("clamp_active", int'(active_log2), 5);
            for (int j = 0; j < 31; j++) begin
                step(1'b0, 0);
                pulses += int'(valid_out);
            end
        end
        check("l5_neg_pulses", pulses, 1);
        check("l5_neg_data", last_data, -65536);

        // 4. L change mid-block applies only to the next block
        log2_decim = 3'd2;
        step(1'b1, 4);
        step(1'b1, 4);
        log2_decim = 3'd3;
        step(1'b1, 4);
        step(1'b1, 4);
        check("chg_valid_a", int'(valid_out), 1);
        check("chg_data_a", sdata(), 8);
        check("chg_active_a", int'(active_log2), 2);
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 3);
            pulses += int'(valid_out);
        end
        check("chg_no_early", pulses, 0);
        check("chg_active_b", int'(active_log2), 3);
        step(1'b1, 3);
        check("chg_valid_b", int'(valid_out), 1);
        check("chg_data_b", sdata(), 6);

        // 5. Enable drop discards partial block
        log2_decim = 3'd3;
        for (int i = 0; i < 5; i++) step(1'b1, 100);
        enable = 1'b0;
        step(1'b1, 100);
        check("en_off_valid", int'(valid_out), 0);
        check("en_off_hold", sdata(), 6);
        enable = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 10);
            if (i < 7) pulses += int'(valid_out);
        end
        check("en_no_early", pulses, 0);
        check("en_valid", int'(valid_out), 1);
        check("en_data", sdata(), 20);

        // 6. Reset mid-block
        log2_decim = 3'd2;
        step(1'b1, 50);
        step(1'b1, 50);
        reset = 1'b1;
        step(1'b1, 50);
        check("rst_valid", int'(valid_out), 0);
        check("rst_data", sdata(), 0);
        check("rst_active", int'(active_log2), 0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4);
            if (i < 3) pulses += int'(valid_out);
        end
        check("rst_no_early", pulses, 0);
        check("rst_valid_after", int'(valid_out), 1);
        check("rst_data_after", sdata(), 8);
        check("rst_active_after", int'(active_log2), 2);

        step(1'b0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
